// File: rtl/sdhci_cmd_ctrl.sv
// SD CMD line sequencer: frames a command with CRC7, collects the card response, reports status.
// Define SDHCI_CMD_RESP_CRC_EN to build the response CRC7 checker; otherwise crc_err_o is tied low.
`timescale 1ns/1ps
module sdhci_cmd_ctrl #(
  parameter int unsigned RespTimeout = 64,
  parameter int unsigned NccCycles   = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   resp_type_i,
  input  logic [7:0]   clk_div_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [119:0] resp_o,
  output logic         timeout_o,
  output logic         crc_err_o,
  output logic         end_err_o,
  output logic         sd_clk_o,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe_o,
  input  logic         sd_cmd_i
);
  localparam int unsigned WaitW = $clog2(RespTimeout + 1);
  localparam int unsigned NccW  = $clog2(NccCycles + 1);
  localparam logic [1:0] RespNone = 2'b00;
  localparam logic [1:0] RespR2   = 2'b10;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, NCC} state_t;

  state_t             state;
  logic [1:0]         type_q;
  logic [7:0]         div_q;
  logic [7:0]         div_cnt;
  logic [46:0]        tx_sr;
  logic [126:0]       rx_sr;
  logic [7:0]         bit_cnt;
  logic [WaitW-1:0]   wait_cnt;
  logic [NccW-1:0]    ncc_cnt;
  logic [1:0]         cmd_sync;

  logic               div_wrap_c;
  logic               sd_rise_c;
  logic               sd_fall_c;
  logic               rx_last_c;
  logic [127:0]       rx_next_c;
  logic [39:0]        frame_head_c;
  logic [47:0]        frame_c;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  function automatic logic [6:0] crc7_block(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  assign frame_head_c = {2'b01, cmd_index_i, cmd_arg_i};
  assign frame_c      = {frame_head_c, crc7_block(frame_head_c), 1'b1};

  // sd_clk edge strobes: the divider wraps on the cycle the card clock toggles
  assign div_wrap_c = (div_cnt == div_q);
  assign sd_rise_c  = busy_o && div_wrap_c && !sd_clk_o;
  assign sd_fall_c  = busy_o && div_wrap_c && sd_clk_o;
  assign rx_next_c  = {rx_sr, cmd_sync[1]};
  assign rx_last_c  = (bit_cnt == ((type_q == RespR2) ? 8'd135 : 8'd47));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cmd_sync <= 2'b11;
    else       cmd_sync <= {cmd_sync[0], sd_cmd_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      resp_o      <= '0;
      timeout_o   <= 1'b0;
      end_err_o   <= 1'b0;
      sd_clk_o    <= 1'b0;
      sd_cmd_o    <= 1'b1;
      sd_cmd_oe_o <= 1'b0;
      type_q      <= RespNone;
      div_q       <= '0;
      div_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      ncc_cnt     <= '0;
    end else begin
      done_o <= 1'b0;
      if (busy_o) begin
        if (div_wrap_c) begin
          div_cnt  <= '0;
          sd_clk_o <= ~sd_clk_o;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
      unique case (state)
        IDLE: if (start_i) begin
          type_q      <= resp_type_i;
          div_q       <= clk_div_i;
          div_cnt     <= '0;
          sd_clk_o    <= 1'b0;
          tx_sr       <= frame_c[46:0];
          sd_cmd_o    <= frame_c[47];
          sd_cmd_oe_o <= 1'b1;
          busy_o      <= 1'b1;
          bit_cnt     <= '0;
          resp_o      <= '0;
          timeout_o   <= 1'b0;
          end_err_o   <= 1'b0;
          state       <= SEND;
        end
        SEND: if (sd_fall_c) begin
          if (bit_cnt == 8'd47) begin
            sd_cmd_oe_o <= 1'b0;
            sd_cmd_o    <= 1'b1;
            wait_cnt    <= '0;
            ncc_cnt     <= '0;
            state       <= (type_q == RespNone) ? NCC : WAIT_RESP;
          end else begin
            tx_sr    <= {tx_sr[45:0], 1'b0};
            sd_cmd_o <= tx_sr[46];
            bit_cnt  <= bit_cnt + 8'd1;
          end
        end
        WAIT_RESP: if (sd_rise_c) begin
          if (!cmd_sync[1]) begin
            rx_sr   <= '0;
            bit_cnt <= 8'd1;
            state   <= RECV;
          end else if (wait_cnt == WaitW'(RespTimeout - 1)) begin
            timeout_o <= 1'b1;
            state     <= NCC;
          end else begin
            wait_cnt <= wait_cnt + WaitW'(1);
          end
        end
        RECV: if (sd_rise_c) begin
          rx_sr   <= rx_next_c[126:0];
          bit_cnt <= bit_cnt + 8'd1;
          if (rx_last_c) begin
            end_err_o <= ~rx_next_c[0];
            resp_o    <= (type_q == RespR2) ? rx_next_c[127:8] : {88'd0, rx_next_c[39:8]};
            state     <= NCC;
          end
        end
        NCC: if (sd_fall_c) begin
          if (ncc_cnt == NccW'(NccCycles - 1)) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            ncc_cnt <= ncc_cnt + NccW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDHCI_CMD_RESP_CRC_EN
  logic [6:0] crc_rx;
  logic       crc_in_range_c;
  logic       crc_checked_c;

  // The start bit is consumed in WAIT_RESP; a 0 into a zero CRC leaves it zero, so skipping it is exact.
  assign crc_in_range_c = (type_q == RespR2) ? (bit_cnt >= 8'd8 && bit_cnt < 8'd128)
                                             : (bit_cnt < 8'd40);
  assign crc_checked_c  = (type_q == 2'b01) || (type_q == RespR2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_rx    <= '0;
      crc_err_o <= 1'b0;
    end else if (state == IDLE && start_i) begin
      crc_rx    <= '0;
      crc_err_o <= 1'b0;
    end else if (state == RECV && sd_rise_c) begin
      if (crc_in_range_c) crc_rx <= crc7_step(crc_rx, cmd_sync[1]);
      if (rx_last_c) crc_err_o <= crc_checked_c && (crc_rx != rx_next_c[7:1]);
    end
  end
`else
  logic unused_crc_c;
  assign crc_err_o    = 1'b0;
  assign unused_crc_c = ^rx_next_c[7:1];
`endif

endmodule
